// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Control sequencer for the stopwatch's debounced buttons.
//               Produces the shared sample_tick strobe that paces the
//               debouncers. Edge-detects the start/stop, lap and clear
//               buttons. Runs the IDLE/RUN/PAUSE/LAP state machine and
//               drives the counter enable, counter clear and display freeze.
//
// Ports       : clk          in   system clock
//               rst          in   asynchronous active-high reset
//               bn_start_db  in   debounced start/stop button
//               bn_lap_db    in   debounced lap button
//               bn_clr_db    in   debounced clear button
//               sample_tick  out  one-clk strobe every SAMPLE_DIV clks
//               run_en       out  time counter count-enable
//               clr_pulse    out  one-clk synchronous clear for the counter
//               lap_hold     out  display freeze while high
//               state        out  current FSM state (debug / LEDs)
//
// Options     : LONG_PRESS_CLR_EN - when defined, holding start for
//               LONG_TICKS sample_ticks issues a clear and returns to IDLE.
//
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int SAMPLE_DIV = 100000,
    parameter int LONG_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bn_start_db,
    input  logic       bn_lap_db,
    input  logic       bn_clr_db,
    output logic       sample_tick,
    output logic       run_en,
    output logic       clr_pulse,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int                 c_CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_RUN   = 2'b01;
    localparam logic [1:0] c_ST_PAUSE = 2'b10;
    localparam logic [1:0] c_ST_LAP   = 2'b11;

    logic [c_CNT_W-1:0] r_presc_cnt;
    logic               r_sample_tick;
    logic               r_start_prev;
    logic               r_lap_prev;
    logic               r_clr_prev;
    logic [1:0]         r_state;
    logic               r_run_en;
    logic               r_clr_pulse;
    logic               r_lap_hold;

    logic               w_start_rise;
    logic               w_lap_rise;
    logic               w_clr_rise;
    logic               w_long_clr;
    logic [1:0]         w_state_nxt;
    logic               w_clr_nxt;

    // ------------------------------------------------------------------
    // Prescaler: tick is registered, so it is high during the cycle that
    // follows the edge on which the count wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_cnt   <= '0;
            r_sample_tick <= 1'b0;
        end else if (r_presc_cnt == c_CNT_LAST) begin
            r_presc_cnt   <= '0;
            r_sample_tick <= 1'b1;
        end else begin
            r_presc_cnt   <= r_presc_cnt + c_CNT_ONE;
            r_sample_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Edge detect. Previous values reset high so a button already held
    // when reset releases does not count as a press.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_prev <= 1'b1;
            r_lap_prev   <= 1'b1;
            r_clr_prev   <= 1'b1;
        end else begin
            r_start_prev <= bn_start_db;
            r_lap_prev   <= bn_lap_db;
            r_clr_prev   <= bn_clr_db;
        end
    end

    assign w_start_rise = bn_start_db & ~r_start_prev;
    assign w_lap_rise   = bn_lap_db   & ~r_lap_prev;
    assign w_clr_rise   = bn_clr_db   & ~r_clr_prev;

`ifdef LONG_PRESS_CLR_EN
    // Hold counter counts sample_ticks while start is held and saturates at
    // LONG_TICKS, so a single hold fires exactly one long-press clear.
    localparam int                  c_HOLD_W    = $clog2(LONG_TICKS + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_FIRE = c_HOLD_W'(LONG_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    logic [c_HOLD_W-1:0] r_hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (!bn_start_db) begin
            r_hold_cnt <= '0;
        end else if (r_sample_tick && (r_hold_cnt != c_HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
        end
    end

    // Fires on the edge where the count reaches LONG_TICKS.
    assign w_long_clr = bn_start_db & r_sample_tick & (r_hold_cnt == c_HOLD_FIRE);
`else
    // Feature not built; the comparison is constant false for any legal
    // LONG_TICKS and only keeps the parameter referenced.
    assign w_long_clr = (LONG_TICKS < 0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic. Priority start > clr > lap; lower-priority rises
    // in the same cycle are dropped. A long-press clear overrides all.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_clr_rise && !r_clr_pulse) begin
                    // Suppressed right after a long-press clear so the
                    // pulse can never be two cycles wide.
                    w_clr_nxt = 1'b1;
                end
            end
            c_ST_RUN: begin
                if (w_start_rise) begin
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_lap_rise) begin
                    w_state_nxt = c_ST_LAP;
                end
            end
            c_ST_LAP: begin
                if (w_start_rise) begin
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_lap_rise) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_PAUSE: begin
                if (w_start_rise) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_clr_rise) begin
                    w_state_nxt = c_ST_IDLE;
                    w_clr_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_long_clr) begin
            w_state_nxt = c_ST_IDLE;
            w_clr_nxt   = 1'b1;
        end
    end

    // State and registered output decode, all updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_run_en    <= 1'b0;
            r_clr_pulse <= 1'b0;
            r_lap_hold  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_en    <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_LAP);
            r_clr_pulse <= w_clr_nxt;
            r_lap_hold  <= (w_state_nxt == c_ST_LAP);
        end
    end

    assign sample_tick = r_sample_tick;
    assign run_en      = r_run_en;
    assign clr_pulse   = r_clr_pulse;
    assign lap_hold    = r_lap_hold;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl
//               (SAMPLE_DIV=4, LONG_TICKS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int         c_SAMPLE_DIV = 4;
    localparam int         c_LONG_TICKS = 8;
    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_LAP   = 2'b11;

    logic       clk;
    logic       rst;
    logic       bn_start_db;
    logic       bn_lap_db;
    logic       bn_clr_db;
    logic       sample_tick;
    logic       run_en;
    logic       clr_pulse;
    logic       lap_hold;
    logic [1:0] state;

    int errors;
    int checks;

    stopwatch_ctrl #(
        .SAMPLE_DIV (c_SAMPLE_DIV),
        .LONG_TICKS (c_LONG_TICKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bn_start_db (bn_start_db),
        .bn_lap_db   (bn_lap_db),
        .bn_clr_db   (bn_clr_db),
        .sample_tick (sample_tick),
        .run_en      (run_en),
        .clr_pulse   (clr_pulse),
        .lap_hold    (lap_hold),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bn_start_db = 1'b0;
        bn_lap_db   = 1'b0;
        bn_clr_db   = 1'b0;
        step(2);
        checks++;
        if ({sample_tick, run_en, clr_pulse, lap_hold, state} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_values: got tick/run/clr/hold/state=%b required 000000",
                     {sample_tick, run_en, clr_pulse, lap_hold, state});
        end
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step(1);
            checks++;
            if (sample_tick !== ((n % c_SAMPLE_DIV) == 0)) begin
                errors++;
                $display("FAIL tick_clk%0d: got %b required %b", n, sample_tick,
                         ((n % c_SAMPLE_DIV) == 0));
            end
        end
        checks++;
        if (state !== c_IDLE || run_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got state=%b run_en=%b required 00/0", state, run_en);
        end
    endtask

    task automatic test_start_stop();
        bn_start_db = 1'b1;
        step(1);
        checks++;
        if (state !== c_RUN || run_en !== 1'b1) begin
            errors++;
            $display("FAIL start_to_run: got state=%b run_en=%b required 01/1", state, run_en);
        end
        step(3);    // still held: no second event
        checks++;
        if (state !== c_RUN) begin
            errors++;
            $display("FAIL start_held: got state=%b required 01", state);
        end
        bn_start_db = 1'b0;
        step(1);
        bn_start_db = 1'b1;
        step(1);
        checks++;
        if (state !== c_PAUSE || run_en !== 1'b0) begin
            errors++;
            $display("FAIL start_to_pause: got state=%b run_en=%b required 10/0", state, run_en);
        end
        bn_start_db = 1'b0;
        step(1);
    endtask

    task automatic test_lap();
        // PAUSE -> RUN
        bn_start_db = 1'b1; step(1); bn_start_db = 1'b0; step(1);
        bn_lap_db = 1'b1;
        step(1);
        checks++;
        if (state !== c_LAP || lap_hold !== 1'b1 || run_en !== 1'b1) begin
            errors++;
            $display("FAIL lap_enter: got state=%b hold=%b run_en=%b required 11/1/1",
                     state, lap_hold, run_en);
        end
        step(3);
        checks++;
        if (state !== c_LAP) begin
            errors++;
            $display("FAIL lap_held: got state=%b required 11", state);
        end
        bn_lap_db = 1'b0; step(1);
        bn_lap_db = 1'b1; step(1);
        checks++;
        if (state !== c_RUN || lap_hold !== 1'b0 || run_en !== 1'b1) begin
            errors++;
            $display("FAIL lap_exit_run: got state=%b hold=%b run_en=%b required 01/0/1",
                     state, lap_hold, run_en);
        end
        bn_lap_db = 1'b0; step(1);
        bn_lap_db = 1'b1; step(1);
        bn_lap_db = 1'b0;
        bn_start_db = 1'b1;
        step(1);
        checks++;
        if (state !== c_PAUSE || lap_hold !== 1'b0 || run_en !== 1'b0) begin
            errors++;
            $display("FAIL lap_exit_pause: got state=%b hold=%b run_en=%b required 10/0/0",
                     state, lap_hold, run_en);
        end
        bn_start_db = 1'b0;
        step(1);
    endtask

    task automatic test_clear();
        // In PAUSE
        bn_clr_db = 1'b1;
        step(1);
        checks++;
        if (clr_pulse !== 1'b1 || state !== c_IDLE) begin
            errors++;
            $display("FAIL clr_pause: got clr=%b state=%b required 1/00", clr_pulse, state);
        end
        step(1);
        checks++;
        if (clr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clr_one_cycle: got clr=%b required 0", clr_pulse);
        end
        bn_clr_db = 1'b0; step(1);
        // IDLE: lap ignored
        bn_lap_db = 1'b1; step(1); bn_lap_db = 1'b0;
        checks++;
        if (state !== c_IDLE || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL idle_lap_ignored: got state=%b hold=%b required 00/0", state, lap_hold);
        end
        // IDLE -> RUN, then clear ignored in RUN
        bn_start_db = 1'b1; step(1); bn_start_db = 1'b0; step(1);
        bn_clr_db = 1'b1;
        step(1);
        checks++;
        if (clr_pulse !== 1'b0 || state !== c_RUN) begin
            errors++;
            $display("FAIL clr_in_run: got clr=%b state=%b required 0/01", clr_pulse, state);
        end
        bn_clr_db = 1'b0; step(1);
        // RUN -> PAUSE -> IDLE
        bn_start_db = 1'b1; step(1); bn_start_db = 1'b0; step(1);
        bn_clr_db = 1'b1; step(1); bn_clr_db = 1'b0; step(1);
    endtask

    task automatic test_simultaneous();
        checks++;
        if (state !== c_IDLE) begin
            errors++;
            $display("FAIL simul_setup: got state=%b required 00", state);
        end
        bn_start_db = 1'b1;
        bn_clr_db   = 1'b1;
        step(1);
        checks++;
        if (state !== c_RUN || clr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL simul_start_clr: got state=%b clr=%b required 01/0", state, clr_pulse);
        end
        bn_clr_db = 1'b0;
        step(2);
    endtask

    task automatic test_async_reset_held();
        // In RUN with start still held; assert reset between edges.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sample_tick, run_en, clr_pulse, lap_hold, state} !== 6'b000000) begin
            errors++;
            $display("FAIL async_reset: got tick/run/clr/hold/state=%b required 000000",
                     {sample_tick, run_en, clr_pulse, lap_hold, state});
        end
        step(1);
        rst = 1'b0;     // start still held across release
        step(3);
        checks++;
        if (state !== c_IDLE || run_en !== 1'b0) begin
            errors++;
            $display("FAIL held_at_release: got state=%b run_en=%b required 00/0", state, run_en);
        end
        checks++;
        step(1);        // edge 4 after release
        if (sample_tick !== 1'b1) begin
            errors++;
            $display("FAIL presc_restart: got tick=%b required 1", sample_tick);
        end
        bn_start_db = 1'b0; step(1);
        bn_start_db = 1'b1; step(1);
        checks++;
        if (state !== c_RUN) begin
            errors++;
            $display("FAIL new_rise_after_release: got state=%b required 01", state);
        end
        bn_start_db = 1'b0; step(1);
    endtask

    task automatic test_long_press();
        int  pulses;
        bit  seen;
        rst = 1'b1; step(1); rst = 1'b0;
        step(2);
        bn_start_db = 1'b1;
        step(1);
        checks++;
        if (state !== c_RUN) begin
            errors++;
            $display("FAIL long_start_rise: got state=%b required 01", state);
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(1);
            if (clr_pulse === 1'b1) seen = 1'b1;
        end
`ifdef LONG_PRESS_CLR_EN
        checks++;
        if (!seen || state !== c_IDLE || run_en !== 1'b0 || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL long_clear: got seen=%b state=%b run_en=%b required 1/00/0",
                     seen, state, run_en);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (clr_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || state !== c_IDLE) begin
            errors++;
            $display("FAIL long_single: got pulses=%0d state=%b required 0/00", pulses, state);
        end
`else
        pulses = 0;
        checks++;
        if (seen || state !== c_RUN) begin
            errors++;
            $display("FAIL long_disabled: got seen=%b state=%b required 0/01", seen, state);
        end
`endif
        bn_start_db = 1'b0;
        step(1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_start_stop();
        test_lap();
        test_clear();
        test_simultaneous();
        test_async_reset_held();
        test_long_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
